mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the processor's single-port, fixed-latency data/instruction memory between the CU's instruction-fetch path and its load/store path. It accepts one request at a time through a req/ack handshake, drives one memory access, waits out the memory latency, and returns read data with a one-cycle ack pulse. It sits between the CU and the memory model and is the only block allowed to drive the memory port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range is MEM_LAT >= 1
- One clock; reset is synchronous and active-high.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DATA_W  fetched word, held until next fetch ack
- dm_req  in  1  load/store request, held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_ack  out  1  one-cycle completion pulse
- dm_rdata  out  DATA_W  load data, updated only on load acks
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples if_req and dm_req.
  - If either is high, picks the owner, captures addr, we and wdata into registers, and moves to ISSUE.
  - A fetch always has we = 0.
- ISSUE: mem_en = 1 for one cycle with the captured mem_we, mem_addr and mem_wdata. Moves to WAIT and loads the latency counter, which is $clog2(MEM_LAT+1) bits wide.
- WAIT:
  - Lasts exactly MEM_LAT cycles.
  - On the last WAIT cycle, mem_rdata is captured into the owner's rdata register, for loads and fetches only.
  - Moves to RESP.
- RESP: pulses the owner's ack for one cycle, then moves to IDLE.
- Arbitration when both requests are high in IDLE: dm wins (fixed priority; see Configuration for the alternative).
- Requester rules:
  - Request fields are sampled only at grant; later changes are ignored.
  - Dropping req before ack is a protocol violation. The access still completes and ack still pulses.
  - A requester may present a new request in the cycle after its ack. It is then sampled in IDLE.
- Stores: dm_ack pulses after the same latency; dm_rdata holds its previous value.
- Reset, including mid-access:
  - The FSM goes to IDLE.
  - The counter and all outputs are cleared: if_ack, dm_ack, mem_en, mem_we, busy, mem_addr, mem_wdata, if_rdata and dm_rdata are 0.
  - An in-flight access is abandoned with no ack, and its late mem_rdata is ignored.

## Timing
- With a request first seen in IDLE at cycle t:
  - mem_en is high in cycle t+1.
  - mem_rdata is valid in cycle t+1+MEM_LAT.
  - ack is high in cycle t+2+MEM_LAT.
  - The FSM is back in IDLE at cycle t+3+MEM_LAT.
- Throughput is one access per 3+MEM_LAT cycles. Back-to-back requests from the same or the other requester add no extra bubble.
- All outputs are registered, with no combinational path from any req to any mem_* output.
- if_ack and dm_ack are never high in the same cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On contention, the requester not granted most recently wins.
  - The last_grant register updates on every grant.
  - last_grant resets to dm, so the first contention goes to if.
- MEM_ARB_RR_EN undefined: fixed priority, dm over if. No last_grant register is built.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum state_t {IDLE, ISSUE, WAIT, RESP}
  - typedef enum owner_t {OWN_IF, OWN_DM}
  - the default width constants.
- Sub-module mem_arb_pick: a combinational owner picker with inputs if_req, dm_req and last_grant, and output owner_t. Its round-robin logic sits under MEM_ARB_RR_EN.

## Test plan
- All benches use MEM_LAT = 2.
- Fetch only: if_req with if_addr = 0x10, memory returns 0xDEADBEEF → mem_en high at t+1 with mem_addr = 0x10; if_ack at t+4 with if_rdata = 0xDEADBEEF; busy high from t+1 to t+4.
- Store: dm_req, dm_we = 1, dm_addr = 0x40, dm_wdata = 0x1234 → mem_en and mem_we at t+1 with mem_wdata = 0x1234; dm_ack at t+4; dm_rdata unchanged.
- Contention, macro undefined: both requests high at t → dm acked at t+4, if acked at t+9 (re-sampled in IDLE at t+5).
- Contention, MEM_ARB_RR_EN defined: both requests held for 4 accesses → ack order if, dm, if, dm.
- Reset mid-access: rst high at t+2 of a load → no dm_ack and all outputs 0 at t+3; a re-issued request then completes normally with ack 4 cycles after it is sampled.
- Back-to-back: fetch re-requested the cycle after its ack, 3 times → acks exactly 5 cycles apart, and mem_en never high in two consecutive cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory arbiter.
// The optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int MEM_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner picker for the memory arbiter.
// MEM_ARB_RR_EN defined: on contention the requester not granted most recently wins.
// MEM_ARB_RR_EN undefined: fixed priority, dm over if; last_grant is ignored.
// The result is only meaningful when at least one request is high.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
  input  owner_t last_grant,
  output owner_t owner
);

`ifdef MEM_ARB_RR_EN
  // Round-robin: alternate on contention, otherwise take whoever asks.
  always_comb begin
    owner = OWN_IF;
    if (if_req && dm_req) begin
      owner = (last_grant == OWN_DM) ? OWN_IF : OWN_DM;
    end else if (dm_req) begin
      owner = OWN_DM;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  // Fixed priority: the load/store path always beats instruction fetch.
  always_comb begin
    owner = OWN_IF;
    if (dm_req) begin
      owner = OWN_DM;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one fixed-latency single-port memory between the
// instruction-fetch port (if_*) and the load/store port (dm_*).
// Build option: MEM_ARB_RR_EN selects round-robin instead of dm-first priority.
//
// Handshake: a requester raises <p>_req with its fields and holds it until the
// one-cycle <p>_ack pulse. Fields are captured only at grant (IDLE); later
// changes are ignored. A new request may be raised the cycle after ack. A req
// dropped before ack still gets its access completed and its ack pulsed.
//
// Timeline for a request seen in IDLE at cycle t:
//   t+1            ISSUE : mem_en high
//   t+2..t+1+LAT   WAIT  : mem_rdata captured on the last WAIT cycle
//   t+2+LAT        RESP  : owner's ack high
//   t+3+LAT        IDLE
// Every output is a flop, so no req reaches a mem_* output combinationally.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_t              state_q,     state_d;
  owner_t              owner_q,     owner_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                mem_en_q,    mem_en_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_ack_q,    if_ack_d;
  logic                dm_ack_q,    dm_ack_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
  logic                busy_q,      busy_d;

  owner_t              pick_owner;
  owner_t              last_grant;
  logic                grant;

  // A grant happens only from IDLE when somebody is asking.
  assign grant = (state_q == IDLE) && (if_req || dm_req);

`ifdef MEM_ARB_RR_EN
  owner_t last_grant_q, last_grant_d;

  // Remember who was granted last; starts at dm so the first contention goes to if.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant) begin
      last_grant_d = pick_owner;
    end
  end

  // Last-grant register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= OWN_DM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = OWN_DM;
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_grant (last_grant),
    .owner      (pick_owner)
  );

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d  = pick_owner;
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          if (pick_owner == OWN_DM) begin
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            // Fetches never write memory.
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(MEM_LAT);
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          if (owner_q == OWN_DM) begin
            dm_ack_d = 1'b1;
            // Stores leave the previous load data in place.
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = busy_q;

endmodule
